// File: rtl/parking_spot_allocator.sv
// Entry/exit controller: arbitrates two entry lanes onto one barrier, hands out the
// lowest free spot, times the gate opening and releases spots on exit.
module parking_spot_allocator #(
  parameter int N_SPOTS          = 8,
  parameter int SPOT_W           = 3,
  parameter int GATE_OPEN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         entry_req,
  output logic [1:0]         entry_grant,
  output logic [SPOT_W-1:0]  grant_spot,
  input  logic               exit_req,
  input  logic [SPOT_W-1:0]  exit_spot,
  output logic               exit_ack,
  output logic               exit_err,
  output logic               gate_open,
  output logic [N_SPOTS-1:0] occupancy,
  output logic               full
);

  localparam int CNT_W = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   hold_cnt;
  logic               hold_done;
  logic               rr_ptr;
  logic               grant_fire;
  logic               grant_lane;
  logic [SPOT_W-1:0]  free_spot;
  logic               exit_hit;
  logic [N_SPOTS-1:0] occ_nxt;

  function automatic logic [SPOT_W-1:0] lowest_free(input logic [N_SPOTS-1:0] occ);
    lowest_free = '0;
    for (int i = N_SPOTS - 1; i >= 0; i--)
      if (!occ[i]) lowest_free = SPOT_W'(i);
  endfunction

  assign full      = &occupancy;
  assign hold_done = (hold_cnt == CNT_W'(GATE_OPEN_CYCLES - 1));

  // Allocation works on the pre-edge vector, so a spot freed this cycle is never picked
  always_comb begin
    free_spot  = lowest_free(occupancy);
    grant_fire = (state == IDLE) && !full && (entry_req != 2'b00);
    grant_lane = (&entry_req) ? rr_ptr : entry_req[1];
    exit_hit   = 1'b0;
    for (int i = 0; i < N_SPOTS; i++)
      if (exit_req && (exit_spot == SPOT_W'(i)) && occupancy[i]) exit_hit = 1'b1;
  end

  always_comb begin
    occ_nxt = occupancy;
    for (int i = 0; i < N_SPOTS; i++) begin
      if (grant_fire && (free_spot == SPOT_W'(i))) occ_nxt[i] = 1'b1;
      if (exit_hit && (exit_spot == SPOT_W'(i)))   occ_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_fire) state_nxt = HOLD;
      HOLD:    if (hold_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gate_open = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt    <= '0;
      rr_ptr      <= 1'b0;
      entry_grant <= 2'b00;
      grant_spot  <= '0;
      occupancy   <= '0;
      exit_ack    <= 1'b0;
      exit_err    <= 1'b0;
    end else begin
      if (state == IDLE)   hold_cnt <= '0;
      else if (!hold_done) hold_cnt <= hold_cnt + 1'b1;
      entry_grant <= 2'b00;
      if (grant_fire) begin
        entry_grant <= grant_lane ? 2'b10 : 2'b01;
        grant_spot  <= free_spot;
        rr_ptr      <= ~grant_lane;
      end
      occupancy <= occ_nxt;
      exit_ack  <= exit_hit;
      exit_err  <= exit_req && !exit_hit;
    end
  end

endmodule
